// File: rtl/muldiv_hilo_unit_if.sv
// ID/EX-side bundle for the multiply/divide unit: instruction slot in, stall and HI/LO views out.
// Handshake: Valid_IN qualifies the funct/operands; the EX instruction may retire only while Stall_OUT is 0.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             Valid_IN;
    logic [5:0]       Function_ULA_IN;
    logic [WIDTH-1:0] Operator1_IN;
    logic [WIDTH-1:0] Operator2_IN;
    logic             Stall_OUT;
    logic             Busy_OUT;
    logic [WIDTH-1:0] HiLo_Result_OUT;
    logic             HiLo_Result_Valid_OUT;
    logic [WIDTH-1:0] HI_OUT;
    logic [WIDTH-1:0] LO_OUT;

    modport master (
        output Valid_IN, Function_ULA_IN, Operator1_IN, Operator2_IN,
        input  Stall_OUT, Busy_OUT, HiLo_Result_OUT, HiLo_Result_Valid_OUT, HI_OUT, LO_OUT
    );

    modport slave (
        input  Valid_IN, Function_ULA_IN, Operator1_IN, Operator2_IN,
        output Stall_OUT, Busy_OUT, HiLo_Result_OUT, HiLo_Result_Valid_OUT, HI_OUT, LO_OUT
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative EX-stage multiply/divide unit: WIDTH-cycle shift-add / restoring divide on magnitudes,
// sign fix-up on the last step, architectural HI/LO with single-cycle MFHI/MFLO/MTHI/MTLO.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                clear,
    muldiv_hilo_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_div_zero;

    logic             w_is_mult, w_is_multu, w_is_div, w_is_divu;
    logic             w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
    logic             w_start, w_signed, w_s1, w_s2, w_last;
    logic [WIDTH-1:0] w_mag1, w_mag2;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;
    logic             w_stall;
    logic [WIDTH-1:0] w_hilo_result;
    logic             w_hilo_valid;

    always_comb begin
        w_is_mfhi  = (bus.Function_ULA_IN == F_MFHI);
        w_is_mthi  = (bus.Function_ULA_IN == F_MTHI);
        w_is_mflo  = (bus.Function_ULA_IN == F_MFLO);
        w_is_mtlo  = (bus.Function_ULA_IN == F_MTLO);
        w_is_mult  = (bus.Function_ULA_IN == F_MULT);
        w_is_multu = (bus.Function_ULA_IN == F_MULTU);
        w_is_div   = (bus.Function_ULA_IN == F_DIV);
        w_is_divu  = (bus.Function_ULA_IN == F_DIVU);
        w_start    = bus.Valid_IN & (w_is_mult | w_is_multu | w_is_div | w_is_divu);
        w_signed   = w_is_mult | w_is_div;
        w_s1       = w_signed & bus.Operator1_IN[WIDTH-1];
        w_s2       = w_signed & bus.Operator2_IN[WIDTH-1];
        w_mag1     = w_s1 ? -bus.Operator1_IN : bus.Operator1_IN;
        w_mag2     = w_s2 ? -bus.Operator2_IN : bus.Operator2_IN;
        w_last     = (r_count == LAST);
    end

    // One iteration: multiply shifts {acc_hi, multiplier} right after a conditional add;
    // divide shifts the dividend into the remainder and subtracts when it fits.
    always_comb begin
        w_add   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opb});
        w_sub   = w_shift[WIDTH-1:0] - r_opb;
        if (r_is_div) begin
            w_step_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_ge};
        end else begin
            w_step_hi = w_add[WIDTH:1];
            w_step_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // A zero divisor leaves |dividend| in the remainder, so the normal sign fix-up restores the dividend.
    always_comb begin
        w_prod     = {w_step_hi, w_step_lo};
        w_prod_fix = r_neg_lo ? -w_prod : w_prod;
        if (r_is_div) begin
            w_res_hi = r_neg_hi ? -w_step_hi : w_step_hi;
            w_res_lo = r_div_zero ? {WIDTH{1'b1}} : (r_neg_lo ? -w_step_lo : w_step_lo);
        end else begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_BUSY;
            S_BUSY:  if (w_last)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall       = 1'b0;
        w_hilo_result = '0;
        w_hilo_valid  = bus.Valid_IN & (w_is_mfhi | w_is_mflo);
        if (!clear) begin
            w_stall = ((r_state == S_IDLE) & w_start) | ((r_state == S_BUSY) & !w_last);
        end
        if (w_is_mfhi) begin
            w_hilo_result = r_hi;
        end else if (w_is_mflo) begin
            w_hilo_result = r_lo;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_count    <= '0;
                r_acc_hi   <= '0;
                r_acc_lo   <= w_mag1;
                r_opb      <= w_mag2;
                r_is_div   <= w_is_div | w_is_divu;
                r_neg_lo   <= w_s1 ^ w_s2;
                r_neg_hi   <= w_s1;
                r_div_zero <= (bus.Operator2_IN == '0);
            end else if (bus.Valid_IN & w_is_mthi) begin
                r_hi <= bus.Operator1_IN;
            end else if (bus.Valid_IN & w_is_mtlo) begin
                r_lo <= bus.Operator1_IN;
            end
        end else begin
            r_count  <= r_count + 1'b1;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign bus.Stall_OUT             = w_stall;
    assign bus.Busy_OUT              = (r_state == S_BUSY);
    assign bus.HiLo_Result_OUT       = w_hilo_result;
    assign bus.HiLo_Result_Valid_OUT = w_hilo_valid;
    assign bus.HI_OUT                = r_hi;
    assign bus.LO_OUT                = r_lo;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_muldiv_hilo_unit;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clock;
    logic clear;
    int   total;
    int   bad;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Arithmetic reference: HI/LO from plain integer operators.
    function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (f)
            F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            F_DIVU: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = W'(sa / sb); hi = W'(sa % sb); end
            end
        endcase
    endfunction

    task automatic idle_inputs();
        bus.Valid_IN        = 1'b0;
        bus.Function_ULA_IN = 6'b000000;
        bus.Operator1_IN    = '0;
        bus.Operator2_IN    = '0;
    endtask

    // Issue one mul/div at posedge+1 and hold it while stalled, as ID/EX would.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic [W-1:0] e_hi, e_lo;
        ref_op(f, a, b, e_hi, e_lo);
        bus.Valid_IN        = 1'b1;
        bus.Function_ULA_IN = f;
        bus.Operator1_IN    = a;
        bus.Operator2_IN    = b;
        #1;
        n = 0;
        while (bus.Stall_OUT === 1'b1 && n < 100) begin
            if (n == 5) begin
                total++;
                if (bus.HI_OUT !== m_hi || bus.LO_OUT !== m_lo || bus.Busy_OUT !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_hold f=%b got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=1",
                             f, bus.HI_OUT, bus.LO_OUT, bus.Busy_OUT, m_hi, m_lo);
                end
            end
            n++;
            @(posedge clock);
            #1;
        end
        total++;
        if (n != W) begin
            bad++;
            $display("FAIL stall_cycles f=%b a=%h b=%h got=%0d exp=%0d", f, a, b, n, W);
        end
        @(posedge clock);
        #1;
        idle_inputs();
        m_hi = e_hi;
        m_lo = e_lo;
        total++;
        if (bus.HI_OUT !== e_hi || bus.LO_OUT !== e_lo || bus.Busy_OUT !== 1'b0) begin
            bad++;
            $display("FAIL result f=%b a=%h b=%h got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0",
                     f, a, b, bus.HI_OUT, bus.LO_OUT, bus.Busy_OUT, e_hi, e_lo);
        end
    endtask

    task automatic read_hilo(input logic [5:0] f);
        logic [W-1:0] exp_v;
        exp_v = (f == F_MFHI) ? m_hi : m_lo;
        bus.Valid_IN        = 1'b1;
        bus.Function_ULA_IN = f;
        #1;
        total++;
        if (bus.HiLo_Result_OUT !== exp_v || bus.HiLo_Result_Valid_OUT !== 1'b1 || bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL mf_read f=%b got=%h vld=%b stall=%b exp=%h vld=1 stall=0",
                     f, bus.HiLo_Result_OUT, bus.HiLo_Result_Valid_OUT, bus.Stall_OUT, exp_v);
        end
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic write_hilo(input logic [5:0] f, input logic [W-1:0] v, input logic vld);
        bus.Valid_IN        = vld;
        bus.Function_ULA_IN = f;
        bus.Operator1_IN    = v;
        #1;
        total++;
        if (bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL mt_stall f=%b got=%b exp=0", f, bus.Stall_OUT);
        end
        @(posedge clock);
        #1;
        idle_inputs();
        if (vld && f == F_MTHI) m_hi = v;
        if (vld && f == F_MTLO) m_lo = v;
        total++;
        if (bus.HI_OUT !== m_hi || bus.LO_OUT !== m_lo) begin
            bad++;
            $display("FAIL mt_write f=%b vld=%b got hi=%h lo=%h exp hi=%h lo=%h",
                     f, vld, bus.HI_OUT, bus.LO_OUT, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        clear               = 1'b1;
        bus.Valid_IN        = 1'b1;
        bus.Function_ULA_IN = F_MULT;
        bus.Operator1_IN    = 32'd9;
        bus.Operator2_IN    = 32'd9;
        #1;
        total++;
        if (bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b exp=0", bus.Stall_OUT);
        end
        repeat (2) @(posedge clock);
        #1;
        idle_inputs();
        clear = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        total++;
        if (bus.HI_OUT !== '0 || bus.LO_OUT !== '0 || bus.Busy_OUT !== 1'b0 || bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b stall=%b exp all 0",
                     bus.HI_OUT, bus.LO_OUT, bus.Busy_OUT, bus.Stall_OUT);
        end
    endtask

    task automatic test_directed();
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo(F_MFLO);
        read_hilo(F_MFHI);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(F_DIVU, 32'd100, 32'd7);
        run_op(F_DIVU, 32'd100, 32'd0);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_mt_mf();
        write_hilo(F_MTHI, 32'h1234_5678, 1'b1);
        write_hilo(F_MTLO, 32'hCAFE_BABE, 1'b1);
        read_hilo(F_MFHI);
        read_hilo(F_MFLO);
        write_hilo(F_MTHI, 32'hDEAD_0001, 1'b0);
        write_hilo(F_MTLO, 32'hDEAD_0002, 1'b0);
        read_hilo(F_MFHI);
        read_hilo(F_MFLO);
    endtask

    task automatic test_bubble();
        bus.Valid_IN        = 1'b0;
        bus.Function_ULA_IN = F_DIVU;
        bus.Operator1_IN    = 32'd50;
        bus.Operator2_IN    = 32'd3;
        #1;
        total++;
        if (bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL bubble_stall got=%b exp=0", bus.Stall_OUT);
        end
        @(posedge clock);
        #1;
        idle_inputs();
        total++;
        if (bus.Busy_OUT !== 1'b0 || bus.HI_OUT !== m_hi || bus.LO_OUT !== m_lo) begin
            bad++;
            $display("FAIL bubble_state got busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     bus.Busy_OUT, bus.HI_OUT, bus.LO_OUT, m_hi, m_lo);
        end
    endtask

    task automatic test_clear_mid_busy();
        bus.Valid_IN        = 1'b1;
        bus.Function_ULA_IN = F_MULT;
        bus.Operator1_IN    = 32'd7;
        bus.Operator2_IN    = 32'd6;
        repeat (11) @(posedge clock);
        #1;
        clear = 1'b1;
        #1;
        total++;
        if (bus.Stall_OUT !== 1'b0) begin
            bad++;
            $display("FAIL clear_stall_during got=%b exp=0", bus.Stall_OUT);
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
        idle_inputs();
        m_hi = '0;
        m_lo = '0;
        #1;
        total++;
        if (bus.Stall_OUT !== 1'b0 || bus.Busy_OUT !== 1'b0 || bus.HI_OUT !== '0 || bus.LO_OUT !== '0) begin
            bad++;
            $display("FAIL clear_abort got stall=%b busy=%b hi=%h lo=%h exp all 0",
                     bus.Stall_OUT, bus.Busy_OUT, bus.HI_OUT, bus.LO_OUT);
        end
        run_op(F_MULT, 32'd7, 32'd6);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [5:0] ops [4];
        ops[0] = F_MULT;
        ops[1] = F_MULTU;
        ops[2] = F_DIV;
        ops[3] = F_DIVU;
        for (int i = 0; i < 24; i++) begin
            run_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand());
        end
        read_hilo(F_MFHI);
        read_hilo(F_MFLO);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b1;
        idle_inputs();
        @(posedge clock);
        #1;
        test_reset();
        test_directed();
        test_mt_mf();
        test_bubble();
        test_clear_mid_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
